// File: rtl/dm_write_buffer.sv
// Posted-write buffer between the core data-memory port and a slow-write backing memory.
// Optional build macro WB_COALESCE_EN: stores to a pending non-head address merge in place.
module dm_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       DM_read,
    input  logic                       DM_write,
    input  logic [AW-1:0]              DM_address,
    input  logic [DW-1:0]              DM_in,
    output logic [DW-1:0]              DM_out,
    output logic [AW-1:0]              mem_rd_addr,
    input  logic [DW-1:0]              mem_rd_data,
    output logic                       mem_wr_req,
    output logic [AW-1:0]              mem_wr_addr,
    output logic [DW-1:0]              mem_wr_data,
    input  logic                       mem_wr_ack,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    output logic                       buf_full,
    output logic                       buf_empty,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             pop, push, coalesce;
    logic             fwd_hit;
    logic [DW-1:0]    fwd_data;
    logic [PW-1:0]    fwd_idx;
`ifdef WB_COALESCE_EN
    logic [PW-1:0]    merge_idx;
`endif

    assign mem_wr_req  = (count_q != '0);
    assign buf_empty   = (count_q == '0);
    assign buf_full    = (count_q == CW'(DEPTH));
    assign buf_count   = count_q;
    assign overflow    = overflow_q;
    assign mem_rd_addr = DM_address;
    assign mem_wr_addr = mem_wr_req ? addr_q[head_q] : '0;
    assign mem_wr_data = mem_wr_req ? data_q[head_q] : '0;

    // Write path: accept, merge or drop the incoming store.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pop      = mem_wr_req && mem_wr_ack;
        coalesce = 1'b0;
`ifdef WB_COALESCE_EN
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DM_write && valid_q[i] && addr_q[i] == DM_address &&
                (PW'(i) != head_q || !mem_wr_req)) begin
                coalesce  = 1'b1;
                merge_idx = PW'(i);
            end
        end
`endif
        push       = DM_write && !coalesce && (!buf_full || pop);
        overflow_d = overflow_q || (DM_write && !coalesce && buf_full && !pop);

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        valid_d = valid_q;
        if (pop)  valid_d[head_q] = 1'b0;
        if (push) valid_d[tail_q] = 1'b1;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Load path: scan oldest to youngest so the last hit is the youngest match.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (valid_q[fwd_idx] && addr_q[fwd_idx] == DM_address) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
        if (!DM_read)
            DM_out = '0;
        else if (fwd_hit)
            DM_out = fwd_data;
        else
            DM_out = mem_rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the entry array has no reset; valid bits and the output gating cover it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= DM_address;
            data_q[tail_q] <= DM_in;
        end
`ifdef WB_COALESCE_EN
        if (coalesce)
            data_q[merge_idx] <= DM_in;
`endif
    end

endmodule

// File: tb/tb_dm_write_buffer.sv
// Scoreboard bench for dm_write_buffer: a queue model predicts drain order, forwarding and flags.
module tb_dm_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          DM_read, DM_write;
    logic [AW-1:0] DM_address;
    logic [DW-1:0] DM_in, DM_out;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_wr_req, mem_wr_ack;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic [CW-1:0] buf_count;
    logic          buf_full, buf_empty, overflow;

    dm_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .DM_read(DM_read), .DM_write(DM_write), .DM_address(DM_address),
        .DM_in(DM_in), .DM_out(DM_out),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
        .buf_count(buf_count), .buf_full(buf_full), .buf_empty(buf_empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          sb_q[$];
    logic [AW-1:0] drained_a[$];
    logic [DW-1:0] drained_d[$];
    logic          ovf_m;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_load(input logic [AW-1:0] a, input logic [DW-1:0] rdd);
        logic [DW-1:0] r = rdd;
        foreach (sb_q[i]) if (sb_q[i].a == a) r = sb_q[i].d;
        return r;
    endfunction

    // One clock: drive just after negedge, check combinational view, then advance the model at posedge.
    task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic ack, input logic [DW-1:0] rdd);
        bit   full_m, pop_m, coal_m;
        ent_t e;
        DM_read = rd; DM_write = wr; DM_address = a; DM_in = d;
        mem_wr_ack = ack; mem_rd_data = rdd;
        #1;
        check("req",      mem_wr_req, sb_q.size() != 0);
        check("count",    buf_count,  sb_q.size());
        check("full",     buf_full,   sb_q.size() == DEPTH);
        check("empty",    buf_empty,  sb_q.size() == 0);
        check("overflow", overflow,   ovf_m);
        check("rd_addr",  mem_rd_addr, a);
        check("dm_out",   DM_out, rd ? model_load(a, rdd) : '0);
        if (sb_q.size() != 0) begin
            check("wr_addr", mem_wr_addr, sb_q[0].a);
            check("wr_data", mem_wr_data, sb_q[0].d);
        end else begin
            check("wr_addr_idle", mem_wr_addr, 0);
            check("wr_data_idle", mem_wr_data, 0);
        end
        @(posedge clk);
        full_m = (sb_q.size() == DEPTH);
        pop_m  = (sb_q.size() != 0) && ack;
        coal_m = 1'b0;
`ifdef WB_COALESCE_EN
        if (wr)
            for (int i = 1; i < sb_q.size(); i++)
                if (sb_q[i].a == a) begin
                    sb_q[i].d = d;
                    coal_m = 1'b1;
                end
`endif
        if (pop_m) begin
            drained_a.push_back(sb_q[0].a);
            drained_d.push_back(sb_q[0].d);
            void'(sb_q.pop_front());
        end
        if (wr && !coal_m) begin
            if (!full_m || pop_m) begin
                e.a = a; e.d = d;
                sb_q.push_back(e);
            end else begin
                ovf_m = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 1'b0, '0, '0, ack, '0);
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ack);
        step(1'b0, 1'b1, a, d, ack, '0);
    endtask

    // Combinational load probe inside the low clock phase; no edge passes.
    task automatic probe_load(input string tag, input logic [AW-1:0] a,
                              input logic [DW-1:0] rdd, input logic [DW-1:0] exp);
        DM_read = 1'b1; DM_write = 1'b0; DM_address = a; mem_rd_data = rdd; mem_wr_ack = 1'b0;
        #1;
        check(tag, DM_out, exp);
        DM_read = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        DM_read = 1'b0; DM_write = 1'b0; DM_address = '0; DM_in = '0;
        mem_wr_ack = 1'b0; mem_rd_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        drained_a.delete();
        drained_d.delete();
        ovf_m = 1'b0;
    endtask

    task automatic fill4(input logic ack);
        store(32'h10, 32'h1, ack);
        store(32'h14, 32'h2, ack);
        store(32'h18, 32'h3, ack);
        store(32'h1C, 32'h4, ack);
    endtask

    initial begin
        rst = 1'b1;
        DM_read = 1'b0; DM_write = 1'b0; DM_address = '0; DM_in = '0;
        mem_wr_ack = 1'b0; mem_rd_data = 32'h5555;
        ovf_m = 1'b0;
        @(negedge clk);
        check("rst_req",     mem_wr_req,  0);
        check("rst_empty",   buf_empty,   1);
        check("rst_full",    buf_full,    0);
        check("rst_count",   buf_count,   0);
        check("rst_ovf",     overflow,    0);
        check("rst_dm_out",  DM_out,      0);
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        do_reset();

        // Three stores held without ack: head entry must stay stable.
        store(32'h10, 32'hA, 1'b0);
        store(32'h14, 32'hB, 1'b0);
        store(32'h18, 32'hC, 1'b0);
        repeat (5) begin
            idle(1'b0);
            check("t1_wr_addr", mem_wr_addr, 32'h10);
            check("t1_wr_data", mem_wr_data, 32'hA);
        end
        check("t1_count", buf_count, 3);
        check("t1_req",   mem_wr_req, 1);

        // Forwarding picks the youngest match; a miss falls through to memory.
        do_reset();
        store(32'h20, 32'h1, 1'b0);
        store(32'h20, 32'h2, 1'b0);
        probe_load("t2_fwd",  32'h20, 32'hFFFF, 32'h2);
        probe_load("t2_miss", 32'h24, 32'hFFFF, 32'hFFFF);
        step(1'b1, 1'b0, 32'h20, '0, 1'b0, 32'hFFFF);
        // A load concurrent with a store sees only already-buffered entries.
        step(1'b1, 1'b1, 32'h28, 32'h77, 1'b0, 32'hEE);
        probe_load("t2_after", 32'h28, 32'hEE, 32'h77);

        // Full buffer: store dropped without ack, accepted with same-cycle ack.
        do_reset();
        fill4(1'b0);
        store(32'h40, 32'h9, 1'b0);
        check("t3_ovf",   overflow,  1);
        check("t3_count", buf_count, 4);
        idle(1'b0);
        check("t3_ovf_sticky", overflow, 1);
        do_reset();
        fill4(1'b0);
        store(32'h40, 32'h9, 1'b1);
        check("t3b_ovf",   overflow,  0);
        check("t3b_count", buf_count, 4);

        // Back-to-back drain.
        do_reset();
        fill4(1'b0);
        repeat (4) idle(1'b1);
        check("t4_n",  drained_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] exp_a;
            exp_a = 32'h10 + 32'(4 * i);
            if (i < drained_a.size()) check("t4_addr_seq", drained_a[i], exp_a);
        end
        check("t4_req",   mem_wr_req, 0);
        check("t4_empty", buf_empty,  1);

        // Reset asserted mid-handshake discards pending writes.
        do_reset();
        store(32'h10, 32'h1, 1'b0);
        store(32'h14, 32'h2, 1'b0);
        DM_read = 1'b0; DM_write = 1'b0; mem_wr_ack = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("t5_req_in_rst", mem_wr_req, 0);
        rst = 1'b0;
        sb_q.delete();
        ovf_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_req",   mem_wr_req, 0);
        check("t5_count", buf_count,  0);
        probe_load("t5_load", 32'h10, 32'h1234, 32'h1234);

`ifdef WB_COALESCE_EN
        do_reset();
        store(32'h30, 32'h5, 1'b0);
        store(32'h34, 32'h6, 1'b0);
        store(32'h34, 32'h7, 1'b0);
        check("t6_count", buf_count, 2);
        probe_load("t6_fwd", 32'h34, 32'h0, 32'h7);
        repeat (2) idle(1'b1);
        check("t6_n", drained_d.size(), 2);
        if (drained_d.size() == 2) begin
            check("t6_d0", drained_d[0], 32'h5);
            check("t6_d1", drained_d[1], 32'h7);
        end
`endif

        // Random mix of loads, stores and acks over a small address set.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] ra;
            ra = 32'($urandom_range(0, 5)) << 2;
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6), ra,
                 32'($urandom), ($urandom_range(0, 2) == 0), 32'($urandom));
        end
        repeat (DEPTH + 1) idle(1'b1);
        check("final_empty", buf_empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
